// File: rtl/ca_pkg.sv
// ca_pkg
// Shared definitions for the cellular-automaton rule sequencer.
//   state_t      : sequencer FSM states
//   RULE_W       : width of a Wolfram-style rule (8 truth-table entries)
//   rule_lookup  : MSB-first truth-table lookup, rule bit 7 is the output for {l,c,r}=000
package ca_pkg;

    localparam int RULE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Neighbourhood {l,c,r} selects bit 7-k, so rule bit 7 answers pattern 000.
    function automatic logic rule_lookup(input logic [RULE_W-1:0] rule,
                                         input logic l, input logic c, input logic r);
        logic [2:0] k;
        k = {l, c, r};
        return rule[3'd7 - k];
    endfunction

endpackage

// File: rtl/ca_rule_sequencer_if.sv
// ca_rule_sequencer_if
// Host-side bundle of the rule sequencer.
//   cfg_we/cfg_rule      : rule write (honoured only while not running)
//   start/abort          : run control
//   seed/gens/wrap       : run parameters, latched on an accepted start
//   busy/done            : run status, done is a one-cycle pulse
//   row_out/gen_count    : committed row and generations committed this run
// master = host/test driver, slave = sequencer.
interface ca_rule_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int GEN_W = 8
);
    import ca_pkg::*;

    logic              cfg_we;
    logic [RULE_W-1:0] cfg_rule;
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  seed;
    logic [GEN_W-1:0]  gens;
    logic              wrap;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  row_out;
    logic [GEN_W-1:0]  gen_count;

    modport master (
        output cfg_we, cfg_rule, start, abort, seed, gens, wrap,
        input  busy, done, row_out, gen_count
    );

    modport slave (
        input  cfg_we, cfg_rule, start, abort, seed, gens, wrap,
        output busy, done, row_out, gen_count
    );

endinterface

// File: rtl/ca_rule_lut.sv
// ca_rule_lut
// Purely combinational 3-input truth-table evaluator; the single shared
// logic resource that every cell of the row is time-multiplexed through.
//   rule_i   : 8-bit rule
//   left_i, centre_i, right_i : neighbourhood of the cell being evaluated
//   cell_o   : next value of that cell
module ca_rule_lut
    import ca_pkg::*;
(
    input  logic [RULE_W-1:0] rule_i,
    input  logic              left_i,
    input  logic              centre_i,
    input  logic              right_i,
    output logic              cell_o
);

    assign cell_o = rule_lookup(rule_i, left_i, centre_i, right_i);

endmodule

// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer
// Runs a 1-D cellular automaton for a requested number of generations,
// evaluating one cell per cycle through a single shared ca_rule_lut.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : host interface (ca_rule_sequencer_if.slave)
// Each generation takes WIDTH EVAL cycles plus one COMMIT cycle; row_out
// only moves on seed load or COMMIT so the host never sees a partial row.
module ca_rule_sequencer
    import ca_pkg::*;
#(
    parameter int                WIDTH        = 16,
    parameter int                GEN_W        = 8,
    parameter logic [RULE_W-1:0] RULE_DEFAULT = 8'h54
) (
    input  logic               clk,
    input  logic               rst_n,
    ca_rule_sequencer_if.slave bus
);

    localparam int               IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  row_q, row_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic [GEN_W-1:0]  genCount_q, genCount_d;
    logic [GEN_W-1:0]  gens_q, gens_d;
    logic              wrap_q, wrap_d;
    logic [RULE_W-1:0] rule_q, rule_d;

    logic [WIDTH+1:0]  rowExt;
    logic [2:0]        nbr;
    logic              newCell;
    logic [GEN_W-1:0]  genNext;

    // Row padded with one virtual cell on each side: bit 0 stands for row[-1]
    // and the top bit for row[WIDTH]; both read 0 unless wrapping.
    // Shifting by idx leaves {left, centre, right} of cell idx in the low bits.
    assign rowExt  = {wrap_q & row_q[0], row_q, wrap_q & row_q[WIDTH-1]};
    assign nbr     = 3'(rowExt >> idx_q);
    assign genNext = genCount_q + GEN_W'(1);

    ca_rule_lut u_lut (
        .rule_i   (rule_q),
        .left_i   (nbr[2]),
        .centre_i (nbr[1]),
        .right_i  (nbr[0]),
        .cell_o   (newCell)
    );

    // Next-state and datapath updates. Abort in COMMIT discards the pending
    // generation, so row_out keeps the last fully committed row.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        shadow_d   = shadow_q;
        genCount_d = genCount_q;
        gens_d     = gens_q;
        wrap_d     = wrap_q;
        rule_d     = rule_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_we) rule_d = bus.cfg_rule;
                if (bus.start) begin
                    row_d      = bus.seed;
                    gens_d     = bus.gens;
                    wrap_d     = bus.wrap;
                    genCount_d = '0;
                    idx_d      = '0;
                    state_d    = (bus.gens == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    shadow_d[idx_q] = newCell;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            COMMIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    row_d      = shadow_q;
                    genCount_d = genNext;
                    idx_d      = '0;
                    state_d    = (genNext == gens_q) ? DONE : EVAL;
                end
            end
            DONE: begin
                if (bus.cfg_we) rule_d = bus.cfg_rule;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            shadow_q   <= '0;
            genCount_q <= '0;
            gens_q     <= '0;
            wrap_q     <= 1'b0;
            rule_q     <= RULE_DEFAULT;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            shadow_q   <= shadow_d;
            genCount_q <= genCount_d;
            gens_q     <= gens_d;
            wrap_q     <= wrap_d;
            rule_q     <= rule_d;
        end
    end

    assign bus.busy      = (state_q == EVAL) || (state_q == COMMIT);
    assign bus.done      = (state_q == DONE);
    assign bus.row_out   = row_q;
    assign bus.gen_count = genCount_q;

endmodule
